// File: rtl/top_master_pkg.sv
// Shared definitions for the microwave-oven controller: oven states,
// UART receiver states, VGA 640x480 timing, UART command bytes and
// small helpers for time clamping and 7-segment decoding.
package top_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COOK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [5:0] MAX_UNIT = 6'd59;

    // VGA 640x480, counted in pixel-enable periods
    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_TOTAL      = 10'd800;
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_TOTAL      = 10'd525;

    localparam logic [7:0] CMD_UP    = 8'h55;  // 'U'
    localparam logic [7:0] CMD_DWN   = 8'h44;  // 'D'
    localparam logic [7:0] CMD_START = 8'h53;  // 'S'

    function automatic logic [5:0] clamp_unit(input logic [5:0] v);
        return (v > MAX_UNIT) ? MAX_UNIT : v;
    endfunction

    // Tens digit of a 0..59 value
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        if (v >= 6'd50)      return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v);
        return 4'(v - 6'(tens_of(v)) * 6'd10);
    endfunction

    // Active-low segments ordered {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

endpackage

// File: rtl/top_master_debounce.sv
// Button conditioner: 2-FF synchronizer followed by a stability filter.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive cycles
// of disagreement with the current accepted level; an accepted rising
// edge produces a single-cycle pulse.
module top_master_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_pulse
);

    localparam int              CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_pulse;
    logic          w_sync;

    assign w_sync  = r_sync[1];
    assign o_pulse = r_pulse;

    // Bring the raw button into the clock domain
    always_ff @(posedge i_clk) begin
        if (i_rst) r_sync <= 2'b00;
        else       r_sync <= {r_sync[0], i_raw};
    end

    // Down-count while the input disagrees with the accepted level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (w_sync == r_stable) begin
                r_cnt <= RELOAD;
            end else if (r_cnt == '0) begin
                r_stable <= w_sync;
                r_pulse  <= w_sync;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/top_master.sv
// Microwave-oven controller top level: MM:SS cook timer, 8-digit
// multiplexed 7-segment display, status LEDs and a 640x480 VGA state
// colour. Optional UART command input enabled by defining UART_CMD_EN.
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | time adjustable by up/down, start begins cook
// ST_COOK | counting down once per tick, buttons ignored
// ST_DONE | reached 00:00, start reloads preset -> idle
module top_master
    import top_master_pkg::*;
#(
    parameter int CLK_HZ          = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REFRESH_CYCLES  = 100_000,
    parameter int TICK_CYCLES     = CLK_HZ,
    parameter int CLKS_PER_BIT    = 868
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       btn_up,
    input  logic       btn_dwn,
    input  logic       btn_start,
    input  logic       rx,
    input  logic [5:0] load_minutes,
    input  logic [5:0] load_seconds,
    output logic [7:0] AN,
    output logic [6:0] display,
    output logic       DP,
    output logic [15:0] LED,
    output logic       start,
    output logic       idle,
    output logic       Hsynq,
    output logic       Vsynq,
    output logic [3:0] Red,
    output logic [3:0] Green,
    output logic [3:0] Blue
);

    localparam int            TW        = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam int            RW        = $clog2(REFRESH_CYCLES);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYCLES - 1);

    state_t        r_state, w_state_nxt;
    logic [5:0]    r_min, r_sec, w_min_nxt, w_sec_nxt;
    logic [TW-1:0] r_tick;
    logic          w_tick;
    logic          w_btn_up_p, w_btn_dwn_p, w_btn_start_p;
    logic          w_uart_up, w_uart_dwn, w_uart_start;
    logic          w_up_p, w_dwn_p, w_start_p;

    top_master_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .i_clk(sys_clk), .i_rst(sys_rst), .i_raw(btn_up), .o_pulse(w_btn_up_p));
    top_master_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dwn (
        .i_clk(sys_clk), .i_rst(sys_rst), .i_raw(btn_dwn), .o_pulse(w_btn_dwn_p));
    top_master_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_start (
        .i_clk(sys_clk), .i_rst(sys_rst), .i_raw(btn_start), .o_pulse(w_btn_start_p));

`ifdef UART_CMD_EN
    localparam int            UW       = $clog2(CLKS_PER_BIT);
    localparam logic [UW-1:0] BIT_LAST = UW'(CLKS_PER_BIT - 1);
    localparam logic [UW-1:0] HALF     = UW'(CLKS_PER_BIT / 2 - 1);

    rx_state_t     r_rx_state, w_rx_state_nxt;
    logic [1:0]    r_rx_sync;
    logic [UW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_rx_byte;
    logic          r_rx_valid;
    logic          w_rx;
    logic          w_rx_cnt_zero;

    assign w_rx          = r_rx_sync[1];
    assign w_rx_cnt_zero = (r_rx_cnt == '0);

    // Receiver state register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_rx_state <= RX_IDLE;
        else         r_rx_state <= w_rx_state_nxt;
    end

    // Receiver next state; a start bit gone high by mid-bit is dropped
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (!w_rx) w_rx_state_nxt = RX_START;
            RX_START: if (w_rx_cnt_zero) w_rx_state_nxt = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_cnt_zero && r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
            RX_STOP:  if (w_rx_cnt_zero) w_rx_state_nxt = RX_IDLE;
            default:  w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // Receiver datapath: mid-bit sampling with a reloading down-counter
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_rx_sync  <= 2'b11;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_byte  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], rx};
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= HALF;
                    r_rx_bit <= '0;
                end
                RX_START: begin
                    if (w_rx_cnt_zero) r_rx_cnt <= BIT_LAST;
                    else               r_rx_cnt <= r_rx_cnt - 1'b1;
                end
                RX_DATA: begin
                    if (w_rx_cnt_zero) begin
                        r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        r_rx_cnt   <= BIT_LAST;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (w_rx_cnt_zero) begin
                        r_rx_valid <= w_rx;
                        r_rx_byte  <= r_rx_shift;
                    end else begin
                        r_rx_cnt <= r_rx_cnt - 1'b1;
                    end
                end
                default: r_rx_cnt <= '0;
            endcase
        end
    end

    assign w_uart_up    = r_rx_valid && (r_rx_byte == CMD_UP);
    assign w_uart_dwn   = r_rx_valid && (r_rx_byte == CMD_DWN);
    assign w_uart_start = r_rx_valid && (r_rx_byte == CMD_START);
`else
    logic w_unused_rx;
    assign w_unused_rx  = rx;
    assign w_uart_up    = 1'b0;
    assign w_uart_dwn   = 1'b0;
    assign w_uart_start = 1'b0;
`endif

    assign w_up_p    = w_btn_up_p    | w_uart_up;
    assign w_dwn_p   = w_btn_dwn_p   | w_uart_dwn;
    assign w_start_p = w_btn_start_p | w_uart_start;

    // Countdown second tick, restarted on every entry to cooking
    always_ff @(posedge sys_clk) begin
        if (sys_rst || r_state != ST_COOK || r_tick == TICK_LAST) r_tick <= '0;
        else                                                     r_tick <= r_tick + 1'b1;
    end

    assign w_tick = (r_state == ST_COOK) && (r_tick == TICK_LAST);

    // Oven state and time registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_min   <= clamp_unit(load_minutes);
            r_sec   <= clamp_unit(load_seconds);
        end else begin
            r_state <= w_state_nxt;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
        end
    end

    // Next state and time; in idle start beats up beats down
    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        case (r_state)
            ST_IDLE: begin
                if (w_start_p) begin
                    if (r_min != 6'd0 || r_sec != 6'd0) w_state_nxt = ST_COOK;
                end else if (w_up_p) begin
                    if (r_min < MAX_UNIT) w_min_nxt = r_min + 6'd1;
                end else if (w_dwn_p) begin
                    if (r_min != 6'd0) w_min_nxt = r_min - 6'd1;
                end
            end
            ST_COOK: begin
                if (w_tick) begin
                    if (r_sec != 6'd0) begin
                        w_sec_nxt = r_sec - 6'd1;
                        if (r_min == 6'd0 && r_sec == 6'd1) w_state_nxt = ST_DONE;
                    end else begin
                        w_sec_nxt = MAX_UNIT;
                        w_min_nxt = r_min - 6'd1;
                    end
                end
            end
            ST_DONE: begin
                w_min_nxt = 6'd0;
                w_sec_nxt = 6'd0;
                if (w_start_p) begin
                    w_state_nxt = ST_IDLE;
                    w_min_nxt   = clamp_unit(load_minutes);
                    w_sec_nxt   = clamp_unit(load_seconds);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign idle  = (r_state == ST_IDLE);
    assign start = (r_state == ST_COOK);

    logic [15:0] r_led;
    assign LED = r_led;

    // Status LEDs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) r_led <= '0;
        else         r_led <= {(r_state == ST_DONE) ? 2'b11 : 2'b00,
                               r_state == ST_COOK, r_state == ST_IDLE, r_min, r_sec};
    end

    logic [RW-1:0] r_refresh;
    logic [1:0]    r_digit;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    w_digit_val;

    // Digit scan timer
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_refresh <= '0;
            r_digit   <= '0;
        end else if (r_refresh == REF_LAST) begin
            r_refresh <= '0;
            r_digit   <= r_digit + 2'd1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // Digit value for the scanned position: sec ones, sec tens, min ones, min tens
    always_comb begin
        w_digit_val = '0;
        case (r_digit)
            2'd0:    w_digit_val = ones_of(r_sec);
            2'd1:    w_digit_val = tens_of(r_sec);
            2'd2:    w_digit_val = ones_of(r_min);
            default: w_digit_val = tens_of(r_min);
        endcase
    end

    // Display drivers; DP marks the minutes-ones digit as the separator
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_an  <= 8'hFF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= {4'hF, ~(4'b0001 << r_digit)};
            r_seg <= seg_decode(w_digit_val);
            r_dp  <= (r_digit != 2'd2);
        end
    end

    assign AN      = r_an;
    assign display = r_seg;
    assign DP      = r_dp;

    logic [1:0]  r_pix_div;
    logic [9:0]  r_hcnt, r_vcnt;
    logic        r_hs, r_vs;
    logic [11:0] r_rgb;
    logic        w_pix_en;

    assign w_pix_en = (r_pix_div == 2'd3);

    // VGA pixel raster counters
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pix_div <= '0;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
        end else begin
            r_pix_div <= r_pix_div + 2'd1;
            if (w_pix_en) begin
                if (r_hcnt == H_TOTAL - 10'd1) begin
                    r_hcnt <= '0;
                    r_vcnt <= (r_vcnt == V_TOTAL - 10'd1) ? 10'd0 : r_vcnt + 10'd1;
                end else begin
                    r_hcnt <= r_hcnt + 10'd1;
                end
            end
        end
    end

    // VGA syncs and state colour
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_rgb <= '0;
        end else begin
            r_hs <= !(r_hcnt >= H_SYNC_START && r_hcnt <= H_SYNC_END);
            r_vs <= !(r_vcnt >= V_SYNC_START && r_vcnt <= V_SYNC_END);
            if (r_hcnt < H_ACTIVE && r_vcnt < V_ACTIVE) begin
                case (r_state)
                    ST_IDLE: r_rgb <= 12'h0F0;
                    ST_COOK: r_rgb <= 12'hF00;
                    ST_DONE: r_rgb <= 12'h00F;
                    default: r_rgb <= 12'h000;
                endcase
            end else begin
                r_rgb <= '0;
            end
        end
    end

    assign Hsynq = r_hs;
    assign Vsynq = r_vs;
    assign Red   = r_rgb[11:8];
    assign Green = r_rgb[7:4];
    assign Blue  = r_rgb[3:0];

endmodule

// File: tb/tb_top_master.sv
// Directed bench for top_master with shortened debounce/tick/refresh
// periods. UART command tests are included when UART_CMD_EN is defined.
module tb_top_master;

    localparam int DEB = 100;
    localparam int TICK = 1000;
    localparam int REF = 10;
    localparam int CPB = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       btn_up = 1'b0, btn_dwn = 1'b0, btn_start = 1'b0;
    logic       rx = 1'b1;
    logic [5:0] load_minutes = 6'd0, load_seconds = 6'd2;
    logic [7:0] AN;
    logic [6:0] display;
    logic       DP;
    logic [15:0] LED;
    logic       start, idle, Hsynq, Vsynq;
    logic [3:0] Red, Green, Blue;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    top_master #(
        .CLK_HZ(TICK), .DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF),
        .TICK_CYCLES(TICK), .CLKS_PER_BIT(CPB)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .btn_up(btn_up), .btn_dwn(btn_dwn),
        .btn_start(btn_start), .rx(rx), .load_minutes(load_minutes),
        .load_seconds(load_seconds), .AN(AN), .display(display), .DP(DP),
        .LED(LED), .start(start), .idle(idle), .Hsynq(Hsynq), .Vsynq(Vsynq),
        .Red(Red), .Green(Green), .Blue(Blue)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic do_reset(input logic [5:0] m, input logic [5:0] s);
        load_minutes = m;
        load_seconds = s;
        sys_rst = 1'b1;
        cyc(4);
        sys_rst = 1'b0;
        cyc(3);
    endtask

    task automatic press(input logic u, input logic d, input logic s, input int hold);
        btn_up = u; btn_dwn = d; btn_start = s;
        cyc(hold);
        btn_up = 1'b0; btn_dwn = 1'b0; btn_start = 1'b0;
        cyc(200);
    endtask

    // Waits until the raster is inside the visible part of a line
    task automatic wait_active(output bit ok);
        int n;
        ok = 1'b0;
        n = 0;
        while (Hsynq !== 1'b0 && n < 4000) begin cyc(1); n++; end
        while (Hsynq !== 1'b1 && n < 8000) begin cyc(1); n++; end
        if (n < 8000) begin cyc(200); ok = 1'b1; end
    endtask

    task automatic test_reset;
        logic [6:0] exp_seg [4];
        logic [7:0] exp_an;
        int n;
        exp_seg[0] = 7'h24; exp_seg[1] = 7'h40; exp_seg[2] = 7'h40; exp_seg[3] = 7'h40;
        load_minutes = 6'd0; load_seconds = 6'd2;
        sys_rst = 1'b1;
        cyc(4);
        checks++; if (idle !== 1'b1 || start !== 1'b0) begin errors++;
            $display("FAIL reset_state idle=%b start=%b required 1/0", idle, start); end
        checks++; if (AN !== 8'hFF || display !== 7'h7F || DP !== 1'b1) begin errors++;
            $display("FAIL reset_display AN=%h seg=%h DP=%b required FF/7F/1", AN, display, DP); end
        checks++; if (LED !== 16'h0000) begin errors++;
            $display("FAIL reset_led LED=%h required 0000", LED); end
        checks++; if (Hsynq !== 1'b1 || Vsynq !== 1'b1 || {Red, Green, Blue} !== 12'h000) begin errors++;
            $display("FAIL reset_vga hs=%b vs=%b rgb=%h required 1/1/000", Hsynq, Vsynq, {Red, Green, Blue}); end
        sys_rst = 1'b0;
        cyc(3);
        checks++; if (LED[12:0] !== 13'h1002) begin errors++;
            $display("FAIL reset_time LED=%h required [12:0]=1002", LED); end
        for (int i = 0; i < 4; i++) begin
            exp_an = ~(8'h01 << i);
            n = 0;
            while (AN !== exp_an && n < 100) begin cyc(1); n++; end
            checks++; if (AN !== exp_an || display !== exp_seg[i] || DP !== (i != 2)) begin errors++;
                $display("FAIL digit%0d AN=%h seg=%h DP=%b required %h/%h/%b",
                         i, AN, display, DP, exp_an, exp_seg[i], i != 2); end
        end
    endtask

    task automatic test_up;
        for (int i = 1; i <= 3; i++) begin
            press(1'b1, 1'b0, 1'b0, 300);
            checks++; if (LED[11:0] !== {6'(i), 6'd2}) begin errors++;
                $display("FAIL up_press%0d time=%h required %h", i, LED[11:0], {6'(i), 6'd2}); end
        end
        press(1'b1, 1'b0, 1'b0, 50);
        checks++; if (LED[11:0] !== {6'd3, 6'd2}) begin errors++;
            $display("FAIL up_glitch time=%h required %h", LED[11:0], {6'd3, 6'd2}); end
    endtask

    task automatic test_down;
        logic [5:0] exp_m;
        for (int i = 0; i < 5; i++) begin
            press(1'b0, 1'b1, 1'b0, 300);
            exp_m = (i < 3) ? 6'(2 - i) : 6'd0;
            checks++; if (LED[11:0] !== {exp_m, 6'd2}) begin errors++;
                $display("FAIL down_press%0d time=%h required %h", i, LED[11:0], {exp_m, 6'd2}); end
        end
    endtask

    task automatic test_cook;
        int n;
        int since_rise;
        bit seen_red;
        bit ok;
        logic prev_hs;
        btn_start = 1'b1;
        n = 0;
        while (start !== 1'b1 && n < 300) begin cyc(1); n++; end
        checks++; if (start !== 1'b1) begin errors++;
            $display("FAIL cook_enter start=%b required 1", start); end
        n = 0;
        since_rise = -1;
        seen_red = 1'b0;
        prev_hs = Hsynq;
        while (start === 1'b1 && n < 3000) begin
            n++;
            if (n == 300) btn_start = 1'b0;
            if (since_rise >= 0) since_rise++;
            if (!prev_hs && Hsynq) since_rise = 0;
            prev_hs = Hsynq;
            if (since_rise == 200 && !seen_red) begin
                seen_red = 1'b1;
                checks++; if ({Red, Green, Blue} !== 12'hF00) begin errors++;
                    $display("FAIL cook_colour rgb=%h required F00", {Red, Green, Blue}); end
            end
            cyc(1);
        end
        btn_start = 1'b0;
        checks++; if (n != 2000) begin errors++;
            $display("FAIL cook_duration cycles=%0d required 2000", n); end
        cyc(2);
        checks++; if (LED[15:14] !== 2'b11 || LED[11:0] !== 12'h000 || idle !== 1'b0) begin errors++;
            $display("FAIL done_state LED=%h idle=%b required 11/000/0", LED, idle); end
        wait_active(ok);
        checks++; if (!ok || {Red, Green, Blue} !== 12'h00F) begin errors++;
            $display("FAIL done_colour rgb=%h ok=%b required 00F", {Red, Green, Blue}, ok); end
        press(1'b0, 1'b0, 1'b1, 300);
        checks++; if (idle !== 1'b1 || LED[15:0] !== 16'h1002) begin errors++;
            $display("FAIL done_ack idle=%b LED=%h required 1/1002", idle, LED); end
    endtask

    task automatic test_zero;
        do_reset(6'd0, 6'd0);
        checks++; if (LED[11:0] !== 12'h000) begin errors++;
            $display("FAIL zero_load time=%h required 000", LED[11:0]); end
        press(1'b0, 1'b0, 1'b1, 300);
        checks++; if (idle !== 1'b1 || start !== 1'b0) begin errors++;
            $display("FAIL zero_start idle=%b start=%b required 1/0", idle, start); end
    endtask

    task automatic test_clamp;
        do_reset(6'd63, 6'd63);
        checks++; if (LED[11:0] !== {6'd59, 6'd59}) begin errors++;
            $display("FAIL clamp_load time=%h required %h", LED[11:0], {6'd59, 6'd59}); end
        press(1'b1, 1'b0, 1'b0, 300);
        checks++; if (LED[11:0] !== {6'd59, 6'd59}) begin errors++;
            $display("FAIL up_saturate time=%h required %h", LED[11:0], {6'd59, 6'd59}); end
        press(1'b0, 1'b1, 1'b0, 300);
        checks++; if (LED[11:0] !== {6'd58, 6'd59}) begin errors++;
            $display("FAIL down_from_59 time=%h required %h", LED[11:0], {6'd58, 6'd59}); end
    endtask

    task automatic test_priority;
        do_reset(6'd0, 6'd2);
        press(1'b1, 1'b1, 1'b0, 300);
        checks++; if (LED[11:0] !== {6'd1, 6'd2}) begin errors++;
            $display("FAIL prio_up_dwn time=%h required %h", LED[11:0], {6'd1, 6'd2}); end
        press(1'b1, 1'b0, 1'b1, 300);
        checks++; if (start !== 1'b1 || LED[11:6] !== 6'd1) begin errors++;
            $display("FAIL prio_start start=%b min=%0d required 1/1", start, LED[11:6]); end
    endtask

    task automatic test_vga;
        int n;
        int low;
        int high;
        bit vs_ok;
        do_reset(6'd0, 6'd2);
        cyc(5);
        checks++; if ({Red, Green, Blue} !== 12'h0F0) begin errors++;
            $display("FAIL idle_colour rgb=%h required 0F0", {Red, Green, Blue}); end
        vs_ok = 1'b1;
        n = 0;
        while (Hsynq !== 1'b0 && n < 4000) begin cyc(1); n++; end
        low = 0;
        while (Hsynq === 1'b0 && low < 4000) begin
            if (Vsynq !== 1'b1) vs_ok = 1'b0;
            cyc(1); low++;
        end
        checks++; if (low != 384) begin errors++;
            $display("FAIL hsync_low cycles=%0d required 384", low); end
        checks++; if ({Red, Green, Blue} !== 12'h000) begin errors++;
            $display("FAIL blank_colour rgb=%h required 000", {Red, Green, Blue}); end
        high = 0;
        while (Hsynq === 1'b1 && high < 4000) begin
            if (Vsynq !== 1'b1) vs_ok = 1'b0;
            cyc(1); high++;
        end
        checks++; if (low + high != 3200) begin errors++;
            $display("FAIL hsync_period cycles=%0d required 3200", low + high); end
        checks++; if (!vs_ok) begin errors++;
            $display("FAIL vsync_early_lines vsync=0 required 1"); end
    endtask

`ifdef UART_CMD_EN
    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(CPB);
        end
        rx = 1'b1;
        cyc(CPB + 10);
    endtask

    task automatic test_uart;
        do_reset(6'd0, 6'd2);
        send_byte(8'h55);
        checks++; if (LED[11:0] !== {6'd1, 6'd2}) begin errors++;
            $display("FAIL uart_U time=%h required %h", LED[11:0], {6'd1, 6'd2}); end
        send_byte(8'h58);
        checks++; if (LED[11:0] !== {6'd1, 6'd2}) begin errors++;
            $display("FAIL uart_X time=%h required %h", LED[11:0], {6'd1, 6'd2}); end
        rx = 1'b0; cyc(4); rx = 1'b1; cyc(3 * CPB);
        send_byte(8'h44);
        checks++; if (LED[11:0] !== {6'd0, 6'd2}) begin errors++;
            $display("FAIL uart_D time=%h required %h", LED[11:0], {6'd0, 6'd2}); end
        send_byte(8'h53);
        checks++; if (start !== 1'b1) begin errors++;
            $display("FAIL uart_S start=%b required 1", start); end
    endtask
`endif

    initial begin
        test_reset;
        test_up;
        test_down;
        test_cook;
        test_zero;
        test_clamp;
        test_priority;
        test_vga;
`ifdef UART_CMD_EN
        test_uart;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
